// File: rtl/nibble_serial_alu_pkg.sv
// rtl/nibble_serial_alu_pkg.sv - shared types and constants for the nibble-serial ALU
package nibble_serial_alu_pkg;

  localparam int NIBBLES = 8;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    AND   = 3'd1,
    OR    = 3'd2,
    XOR   = 3'd3,
    RSHFT = 3'd4
  } AluCmd;

  typedef struct packed {
    AluCmd cmd;
    logic  carry_in;
  } AluCtrl;

  // Shifts walk the word from the top nibble down so the carried bit lands in the next lower nibble.
  function automatic logic is_descending(input AluCmd c);
    return (c == RSHFT);
  endfunction

endpackage

// File: rtl/nibble_serial_alu_alu.sv
// rtl/nibble_serial_alu_alu.sv - combinational 4-bit ALU slice with carry chaining
module alu
  import nibble_serial_alu_pkg::*;
(
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  AluCtrl     ctrl,
  output logic [3:0] res,
  output logic       carry_out
);

  logic [4:0] sum;

  assign sum = {1'b0, d1} + {1'b0, d2} + {4'b0000, ctrl.carry_in};

  always_comb begin
    res       = 4'h0;
    carry_out = 1'b0;
    case (ctrl.cmd)
      ADD: begin
        res       = sum[3:0];
        carry_out = sum[4];
      end
      AND:   res = d1 & d2;
      OR:    res = d1 | d2;
      XOR:   res = d1 ^ d2;
      RSHFT: begin
        res       = {ctrl.carry_in, d2[3:1]};
        carry_out = d2[0];
      end
      default: begin
        res       = 4'h0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/nibble_serial_alu_counter.sv
// rtl/nibble_serial_alu_counter.sv - 3-bit up/down nibble index with end-of-word flag
module nibble_counter
  import nibble_serial_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       reverse,
  input  logic       load,
  output logic [2:0] idx,
  output logic       is_latest
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 3'd0;
    end else if (load) begin
      idx <= reverse ? 3'(NIBBLES - 1) : 3'd0;
    end else if (en) begin
      idx <= reverse ? idx - 3'd1 : idx + 3'd1;
    end
  end

  assign is_latest = reverse ? (idx == 3'd0) : (idx == 3'(NIBBLES - 1));

endmodule

// File: rtl/nibble_serial_alu.sv
// rtl/nibble_serial_alu.sv - 32-bit ALU processing one nibble per clock
module nibble_serial_alu
  import nibble_serial_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  AluCmd       cmd,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  output logic        busy,
  output logic [31:0] result
);

  AluCmd       cmd_q;
  logic [31:0] word1_q;
  logic [31:0] word2_q;
  logic        carry_q;

  logic        accept;
  logic        reverse;
  logic [2:0]  idx;
  logic        is_latest;

  logic [3:0]  nib1 [NIBBLES];
  logic [3:0]  nib2 [NIBBLES];
  AluCtrl      ctrl;
  logic [3:0]  alu_res;
  logic        alu_carry;

  assign accept = start && !busy;

  // Direction must be known on the load edge, before cmd_q has captured the new command.
  assign reverse = accept ? is_descending(cmd) : is_descending(cmd_q);

  nibble_counter u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .reverse   (reverse),
    .load      (accept),
    .idx       (idx),
    .is_latest (is_latest)
  );

  always_comb begin
    for (int i = 0; i < NIBBLES; i++) begin
      nib1[i] = word1_q[i*4 +: 4];
      nib2[i] = word2_q[i*4 +: 4];
    end
  end

  assign ctrl.cmd      = cmd_q;
  assign ctrl.carry_in = carry_q;

  alu u_alu (
    .d1        (nib1[idx]),
    .d2        (nib2[idx]),
    .ctrl      (ctrl),
    .res       (alu_res),
    .carry_out (alu_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      result  <= 32'h0;
      carry_q <= 1'b0;
      cmd_q   <= ADD;
      word1_q <= 32'h0;
      word2_q <= 32'h0;
    end else if (accept) begin
      busy    <= 1'b1;
      result  <= 32'h0;
      carry_q <= 1'b0;
      cmd_q   <= cmd;
      word1_q <= word1;
      word2_q <= word2;
    end else if (busy) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == 3'(i)) begin
          result[i*4 +: 4] <= alu_res;
        end
      end
      carry_q <= alu_carry;
      if (is_latest) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb/tb_nibble_serial_alu.sv - directed self-checking bench for nibble_serial_alu
module tb_nibble_serial_alu;
  import nibble_serial_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  AluCmd       cmd;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        busy;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  nibble_serial_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmd    (cmd),
    .word1  (word1),
    .word2  (word2),
    .busy   (busy),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the first negedge with busy low.
  task automatic run_op(input string tag, input AluCmd c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit pulse_mid);
    int cycles;
    cmd = c; word1 = a; word2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      cycles++;
      if (pulse_mid && cycles == 3) begin
        start = 1'b1; cmd = ADD; word1 = 32'h1111_1111; word2 = 32'h2222_2222;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(cycles), 32'd8);
    chk({tag, "_result"}, result, exp);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; cmd = ADD; word1 = 32'h0; word2 = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    run_op("add_carry_chain", ADD, 32'hEFFF_FFFF, 32'h0000_0001, 32'hF000_0000, 1'b0);
    run_op("add_mid_carry", ADD, 32'hFFFF_0FFF, 32'h0000_0002, 32'hFFFF_1001, 1'b0);
    run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    run_op("add_mixed", ADD, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0);
    run_op("rshft_basic", RSHFT, 32'hDEAD_BEEF, 32'h0600_0000, 32'h0300_0000, 1'b0);
    run_op("rshft_lsb_out", RSHFT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    run_op("rshft_cross", RSHFT, 32'h0, 32'h8000_0011, 32'h4000_0008, 1'b0);
    run_op("xor_mid_start", XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b1);
    run_op("and_op", AND, 32'hF0F0_FFFF, 32'h0FF0_123F, 32'h00F0_123F, 1'b0);
    run_op("or_op", OR, 32'h1234_0000, 32'h0000_ABCD, 32'h1234_ABCD, 1'b0);
    run_op("undef_cmd", AluCmd'(3'd5), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    run_op("hold_setup", ADD, 32'h0000_00F0, 32'h0000_0010, 32'h0000_0100, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_result", result, 32'h0000_0100);
    chk("hold_busy", 32'(busy), 32'd0);

    cmd = ADD; word1 = 32'hFFFF_FFFF; word2 = 32'h0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (busy && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'd0);
    run_op("add_after_reset", ADD, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
